catch_tracker: RTL and testbench

Parametrised catch detector and catch-history recorder for the falling-object game. Takes positions of N_OBJ falling objects (cakes or cherries) and the plate each cycle. Emits one registered, edge-qualified catch event per cycle, with priority arbitration and queuing of simultaneous catches. Logs caught cake colours into a ring buffer that the stacking/display logic reads back in catch order. Sits between the object movers/plate controller and the score/render blocks.

---
 rtl/catch_tracker.sv | 199 +++++++++++++++++++
 tb/tb_catch_tracker.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/catch_tracker.sv
// Catch detector with edge-qualified, priority-arbitrated catch events and an optional
// cake-colour history ring buffer (enabled by CATCH_TRACKER_RECORD_EN).
module catch_tracker #(
    parameter int N_OBJ     = 4,
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int CLR_W     = 3,
    parameter int HALF_W    = 8,
    parameter int CAKE_DY   = 6,
    parameter int CHERRY_DY = 14,
    parameter int DEPTH     = 16,
    localparam int IDX_W    = (N_OBJ > 1) ? $clog2(N_OBJ) : 1,
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int CNT_W    = PTR_W + 1
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [N_OBJ*X_W-1:0]   obj_x,
    input  logic [N_OBJ*Y_W-1:0]   obj_y,
    input  logic [N_OBJ*CLR_W-1:0] obj_clr,
    input  logic [N_OBJ-1:0]       obj_cherry,
    input  logic [X_W-1:0]         plate_x,
    input  logic [Y_W-1:0]         plate_y,
    output logic                   caught_cake,
    output logic                   caught_cherry,
    output logic [CLR_W-1:0]       caught_clr,
    output logic [IDX_W-1:0]       caught_idx,
    input  logic                   rd_en,
    output logic [CLR_W-1:0]       rd_data,
    output logic                   rd_valid,
    output logic [CNT_W-1:0]       rec_count,
    output logic                   rec_empty,
    output logic                   rec_full,
    output logic                   rec_ovf
);

    localparam logic [Y_W:0]          CAKE_DY_W   = (Y_W+1)'(CAKE_DY);
    localparam logic [Y_W:0]          CHERRY_DY_W = (Y_W+1)'(CHERRY_DY);
    localparam logic signed [X_W+1:0] HALF_S      = (X_W+2)'(HALF_W);

    logic [N_OBJ-1:0] hit_d, hit_q;
    logic [N_OBJ-1:0] pend_d, pend_q;
    logic [N_OBJ-1:0] new_evt, cand, cand_ch, cand_ck, sel, grant;
    logic             grant_vld, grant_cherry;
    logic [IDX_W-1:0] grant_idx;
    logic [CLR_W-1:0] grant_clr;

    logic             caught_cake_d, caught_cake_q;
    logic             caught_cherry_d, caught_cherry_q;
    logic [CLR_W-1:0] caught_clr_d, caught_clr_q;
    logic [IDX_W-1:0] caught_idx_d, caught_idx_q;

    // Extra bits keep the y sum from wrapping and make the x difference signed.
    for (genvar g = 0; g < N_OBJ; g++) begin : g_hit
        logic [Y_W:0]          dy;
        logic [Y_W:0]          y_reach;
        logic signed [X_W+1:0] dx;

        assign dy       = obj_cherry[g] ? CHERRY_DY_W : CAKE_DY_W;
        assign y_reach  = {1'b0, obj_y[g*Y_W +: Y_W]} + dy;
        assign dx       = $signed({2'b00, obj_x[g*X_W +: X_W]}) - $signed({2'b00, plate_x});
        assign hit_d[g] = (y_reach >= {1'b0, plate_y}) && (dx <= HALF_S) && (dx >= -HALF_S);
    end

    always_comb begin
        new_evt      = hit_d & ~hit_q;
        cand         = pend_q | new_evt;
        cand_ch      = cand & obj_cherry;
        cand_ck      = cand & ~obj_cherry;
        grant_cherry = |cand_ch;
        sel          = grant_cherry ? cand_ch : cand_ck;
        grant_vld    = |sel;
        grant        = '0;
        grant_idx    = '0;
        grant_clr    = '0;
        for (int i = N_OBJ - 1; i >= 0; i--) begin
            if (sel[i]) begin
                grant     = '0;
                grant[i]  = 1'b1;
                grant_idx = IDX_W'(i);
                grant_clr = obj_clr[i*CLR_W +: CLR_W];
            end
        end
        if (grant_cherry) begin
            grant_clr = '1;
        end
        pend_d          = cand & ~grant;
        caught_cake_d   = grant_vld & ~grant_cherry;
        caught_cherry_d = grant_cherry;
        caught_clr_d    = grant_vld ? grant_clr : '0;
        caught_idx_d    = grant_vld ? grant_idx : '0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            // Objects already inside the window while reset is held count as seen,
            // so they only fire again after leaving and re-entering.
            hit_q           <= hit_d;
            pend_q          <= '0;
            caught_cake_q   <= 1'b0;
            caught_cherry_q <= 1'b0;
            caught_clr_q    <= '0;
            caught_idx_q    <= '0;
        end else begin
            hit_q           <= hit_d;
            pend_q          <= pend_d;
            caught_cake_q   <= caught_cake_d;
            caught_cherry_q <= caught_cherry_d;
            caught_clr_q    <= caught_clr_d;
            caught_idx_q    <= caught_idx_d;
        end
    end

    assign caught_cake   = caught_cake_q;
    assign caught_cherry = caught_cherry_q;
    assign caught_clr    = caught_clr_q;
    assign caught_idx    = caught_idx_q;

`ifdef CATCH_TRACKER_RECORD_EN
    logic [CLR_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_d, wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d, rd_ptr_q;
    logic [CNT_W-1:0] count_d, count_q;
    logic             ovf_d, ovf_q;
    logic             rd_valid_d, rd_valid_q;
    logic [CLR_W-1:0] rd_data_d, rd_data_q;
    logic             rec_wr, rec_rd, full_w, empty_w;

    always_comb begin
        full_w     = (count_q == CNT_W'(DEPTH));
        empty_w    = (count_q == '0);
        rec_wr     = caught_cake_d;
        rec_rd     = rd_en & ~empty_w;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        rd_valid_d = rec_rd;
        rd_data_d  = rec_rd ? mem_q[rd_ptr_q] : rd_data_q;
        if (rec_wr) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        // A write into a full buffer with no read displaces the oldest entry.
        if (rec_rd || (rec_wr && full_w)) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (rec_wr && !rec_rd && !full_w) begin
            count_d = count_q + CNT_W'(1);
        end else if (rec_rd && !rec_wr) begin
            count_d = count_q - CNT_W'(1);
        end
        if (rec_wr && full_w && !rec_rd) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && rec_wr) begin
            mem_q[wr_ptr_q] <= grant_clr;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign rec_count = count_q;
    assign rec_empty = (count_q == '0);
    assign rec_full  = (count_q == CNT_W'(DEPTH));
    assign rec_ovf   = ovf_q;
`else
    logic unused_rd_en;

    assign unused_rd_en = rd_en;
    assign rd_data      = '0;
    assign rd_valid     = 1'b0;
    assign rec_count    = '0;
    assign rec_empty    = 1'b1;
    assign rec_full     = 1'b0;
    assign rec_ovf      = 1'b0;
`endif

endmodule

// File: tb/tb_catch_tracker.sv
// Directed bench for catch_tracker: hit windows, arbitration order, ring buffer, reset.
module tb_catch_tracker;

    localparam int N_OBJ = 4;
    localparam int X_W   = 8;
    localparam int Y_W   = 7;
    localparam int CLR_W = 3;
    localparam int CNT_W = 5;

`ifdef CATCH_TRACKER_RECORD_EN
    localparam bit REC_EN = 1'b1;
`else
    localparam bit REC_EN = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   resetn;
    logic [N_OBJ*X_W-1:0]   obj_x;
    logic [N_OBJ*Y_W-1:0]   obj_y;
    logic [N_OBJ*CLR_W-1:0] obj_clr;
    logic [N_OBJ-1:0]       obj_cherry;
    logic [X_W-1:0]         plate_x;
    logic [Y_W-1:0]         plate_y;
    logic                   caught_cake;
    logic                   caught_cherry;
    logic [CLR_W-1:0]       caught_clr;
    logic [1:0]             caught_idx;
    logic                   rd_en;
    logic [CLR_W-1:0]       rd_data;
    logic                   rd_valid;
    logic [CNT_W-1:0]       rec_count;
    logic                   rec_empty;
    logic                   rec_full;
    logic                   rec_ovf;

    int n_tests = 0;
    int n_fail  = 0;

    catch_tracker dut (
        .clk           (clk),
        .resetn        (resetn),
        .obj_x         (obj_x),
        .obj_y         (obj_y),
        .obj_clr       (obj_clr),
        .obj_cherry    (obj_cherry),
        .plate_x       (plate_x),
        .plate_y       (plate_y),
        .caught_cake   (caught_cake),
        .caught_cherry (caught_cherry),
        .caught_clr    (caught_clr),
        .caught_idx    (caught_idx),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .rec_count     (rec_count),
        .rec_empty     (rec_empty),
        .rec_full      (rec_full),
        .rec_ovf       (rec_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected end of sequence");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_evt(input string tag, input int cake, input int cherry,
                           input int clr, input int idx);
        chk({tag, ".cake"},   32'(caught_cake),   32'(cake));
        chk({tag, ".cherry"}, 32'(caught_cherry), 32'(cherry));
        chk({tag, ".clr"},    32'(caught_clr),    32'(clr));
        chk({tag, ".idx"},    32'(caught_idx),    32'(idx));
    endtask

    // Without the record feature the status outputs are tied off.
    task automatic chk_rec(input string tag, input int cnt, input int emp,
                           input int full, input int ovf);
        chk({tag, ".count"}, 32'(rec_count), REC_EN ? 32'(cnt)  : 32'd0);
        chk({tag, ".empty"}, 32'(rec_empty), REC_EN ? 32'(emp)  : 32'd1);
        chk({tag, ".full"},  32'(rec_full),  REC_EN ? 32'(full) : 32'd0);
        chk({tag, ".ovf"},   32'(rec_ovf),   REC_EN ? 32'(ovf)  : 32'd0);
    endtask

    task automatic chk_rd(input string tag, input int v, input int d);
        chk({tag, ".rd_valid"}, 32'(rd_valid), REC_EN ? 32'(v) : 32'd0);
        chk({tag, ".rd_data"},  32'(rd_data),  REC_EN ? 32'(d) : 32'd0);
    endtask

    task automatic set_obj(input int i, input int x, input int y, input int clr, input bit ch);
        obj_x[i*X_W +: X_W]       = X_W'(x);
        obj_y[i*Y_W +: Y_W]       = Y_W'(y);
        obj_clr[i*CLR_W +: CLR_W] = CLR_W'(clr);
        obj_cherry[i]             = ch;
    endtask

    task automatic park(input int i);
        obj_y[i*Y_W +: Y_W] = '0;
    endtask

    task automatic catch_cake0(input int clr);
        set_obj(0, 80, 94, clr, 1'b0);
        step();
        chk("fill.cake", 32'(caught_cake), 32'd1);
        park(0);
        step();
    endtask

    initial begin
        resetn     = 1'b0;
        obj_x      = '0;
        obj_y      = '0;
        obj_clr    = '0;
        obj_cherry = '0;
        plate_x    = 8'd80;
        plate_y    = 7'd100;
        rd_en      = 1'b0;
        for (int i = 0; i < N_OBJ; i++) set_obj(i, 80, 0, 0, 1'b0);
        step();
        step();
        chk_evt("reset", 0, 0, 0, 0);
        chk_rec("reset", 0, 1, 0, 0);
        chk_rd("reset", 0, 0);
        resetn = 1'b1;

        // single cake: y 93 misses by one, y 94 is the first hit
        set_obj(0, 85, 93, 5, 1'b0);
        step();
        chk_evt("cake_y93", 0, 0, 0, 0);
        set_obj(0, 85, 94, 5, 1'b0);
        step();
        chk_evt("cake_hit", 1, 0, 5, 0);
        chk_rec("cake_hit", 1, 0, 0, 0);
        step();
        chk_evt("cake_after1", 0, 0, 0, 0);
        step();
        chk_evt("cake_after2", 0, 0, 0, 0);
        park(0);
        step();
        rd_en = 1'b1;
        step();
        chk_rd("read1", 1, 5);
        chk_rec("read1", 0, 1, 0, 0);
        step();
        chk_rd("read_empty", 0, 5);
        rd_en = 1'b0;

        // x bounds with a cherry on obj0
        plate_x = 8'd10;
        set_obj(0, 2, 94, 3, 1'b1);
        step();
        chk_evt("x_lo_hit", 0, 1, 7, 0);
        park(0);
        step();
        set_obj(0, 1, 94, 3, 1'b1);
        step();
        chk_evt("x_lo_miss", 0, 0, 0, 0);
        park(0);
        step();
        plate_x = 8'd250;
        set_obj(0, 255, 94, 3, 1'b1);
        step();
        chk_evt("x_hi_hit", 0, 1, 7, 0);
        park(0);
        step();
        plate_x = 8'd10;
        set_obj(0, 200, 94, 3, 1'b1);
        step();
        chk_evt("x_wrap_miss", 0, 0, 0, 0);
        park(0);
        step();
        plate_x = 8'd80;
        set_obj(0, 80, 85, 3, 1'b1);
        step();
        chk_evt("cherry_y85", 0, 0, 0, 0);
        set_obj(0, 80, 86, 3, 1'b1);
        step();
        chk_evt("cherry_y86", 0, 1, 7, 0);
        set_obj(0, 80, 0, 0, 1'b0);
        step();
        chk_rec("x_done", 0, 1, 0, 0);

        // simultaneous: cherry first, then cakes by index; obj3 leaves while pending
        set_obj(1, 80, 94, 2, 1'b0);
        set_obj(2, 80, 94, 3, 1'b1);
        set_obj(3, 80, 94, 6, 1'b0);
        step();
        chk_evt("sim0", 0, 1, 7, 2);
        park(3);
        step();
        chk_evt("sim1", 1, 0, 2, 1);
        step();
        chk_evt("sim2", 1, 0, 6, 3);
        chk_rec("sim2", 2, 0, 0, 0);
        step();
        chk_evt("sim_idle", 0, 0, 0, 0);
        rd_en = 1'b1;
        step();
        chk_rd("sim_rd0", 1, 2);
        step();
        chk_rd("sim_rd1", 1, 6);
        chk_rec("sim_rd1", 0, 1, 0, 0);
        rd_en = 1'b0;
        park(1);
        park(2);
        set_obj(2, 80, 0, 0, 1'b0);
        step();

        // fill to 16, then write+read on a full buffer
        for (int k = 1; k <= 16; k++) catch_cake0(k % 8);
        chk_rec("full16", 16, 0, 1, 0);
        set_obj(0, 80, 94, 17 % 8, 1'b0);
        rd_en = 1'b1;
        step();
        chk_evt("wr_rd_full", 1, 0, 1, 0);
        chk_rd("wr_rd_full", 1, 1);
        chk_rec("wr_rd_full", 16, 0, 1, 0);
        rd_en = 1'b0;
        park(0);
        step();

        // overflow: write into full buffer with no read
        set_obj(0, 80, 94, 18 % 8, 1'b0);
        step();
        chk_rec("ovf", 16, 0, 1, 1);
        park(0);
        step();
        rd_en = 1'b1;
        for (int k = 3; k <= 18; k++) begin
            step();
            chk_rd("drain", 1, k % 8);
        end
        rd_en = 1'b0;
        chk_rec("drained", 0, 1, 0, 1);
        step();
        chk_rd("drain_idle", 0, 18 % 8);

        // reset with 5 records stored and 2 events pending
        for (int k = 1; k <= 4; k++) catch_cake0(k);
        set_obj(0, 80, 94, 5, 1'b0);
        set_obj(1, 80, 94, 6, 1'b0);
        set_obj(2, 80, 94, 7, 1'b0);
        step();
        chk_evt("pre_reset", 1, 0, 5, 0);
        chk_rec("pre_reset", 5, 0, 0, 1);
        resetn = 1'b0;
        step();
        chk_evt("mid_reset", 0, 0, 0, 0);
        chk_rec("mid_reset", 0, 1, 0, 0);
        chk_rd("mid_reset", 0, 0);
        resetn = 1'b1;
        step();
        chk_evt("post_reset1", 0, 0, 0, 0);
        step();
        chk_evt("post_reset2", 0, 0, 0, 0);
        park(1);
        step();
        chk_evt("leave", 0, 0, 0, 0);
        set_obj(1, 80, 94, 6, 1'b0);
        step();
        chk_evt("reenter", 1, 0, 6, 1);
        chk_rec("reenter", 1, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
